// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
//   uart_state_e  - frame FSM states
//   STOP_BITS_1   - stop_bits code for one stop bit; any other code selects two
//   PARITY_EVEN / PARITY_ODD - parity_type encodings
//   parity_bit()  - parity bit for a data byte and parity type
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BAUD_W    = 32;
  localparam int unsigned ACC_W     = 33;
  localparam int unsigned BIT_IDX_W = 3;

  localparam logic [1:0] STOP_BITS_1 = 2'd0;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones even; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic ptype);
    logic p;
    p = ^data;
    unique case (ptype)
      PARITY_EVEN: parity_bit = p;
      PARITY_ODD:  parity_bit = ~p;
      default:     parity_bit = p;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional bit-rate strobe from a phase accumulator.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   clear - restart the phase (frame accept)
//   baud  - line rate in bit/s
//   tick  - one-cycle strobe at the bit rate (combinational from acc)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [BAUD_W-1:0] baud,
  output logic              tick
);

  localparam logic [ACC_W-1:0] CLK_FREQ_A = ACC_W'(CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             saturate;

  assign sum      = acc + ACC_W'(baud);
  assign saturate = (ACC_W'(baud) >= CLK_FREQ_A);
  assign tick     = (sum >= CLK_FREQ_A);

  // Rates at or above the clock tick every cycle with no residual phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear || saturate) begin
      acc <= '0;
    end else if (tick) begin
      acc <= sum - CLK_FREQ_A;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter, LSB first, idle-high line.
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   tx_data, valid  - byte and its configuration offered; taken when valid && ready
//   ready           - combinational: idle and baudrate non-zero
//   baudrate        - line rate in bit/s
//   stop_bits       - 0: one stop bit, 1..3: two stop bits
//   parity_en/type  - parity bit enable, 0 even / 1 odd
//   tx              - registered serial line
//   busy            - registered, high while a frame is in progress
// Build option: UART_TX_PARITY_EN adds the parity bit; without it the
// parity inputs are ignored and frames are 8N1/8N2.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              valid,
  output logic              ready,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic [1:0]        stop_bits,
  input  logic              parity_en,
  input  logic              parity_type,
  output logic              tx,
  output logic              busy
);

  uart_state_e          state, state_next;
  logic [DATA_W-1:0]    data_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [1:0]           stop_q;
  logic [BIT_IDX_W-1:0] bit_idx, bit_idx_next;
  logic                 stop_idx, stop_idx_next;
  logic                 tx_next;
  logic                 accept;
  logic                 tick;
  logic                 two_stop;

  assign ready    = (state == ST_IDLE) && (baudrate != '0);
  assign accept   = valid && ready;
  assign two_stop = (stop_q != STOP_BITS_1);

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_type_q;
  logic par_bit;

  assign par_bit = parity_bit(data_q, par_type_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
    end else if (accept) begin
      par_en_q   <= parity_en;
      par_type_q <= parity_type;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_type;
`endif

  // Frame configuration is frozen at accept for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      baud_q <= '0;
      stop_q <= '0;
    end else if (accept) begin
      data_q <= tx_data;
      baud_q <= baudrate;
      stop_q <= stop_bits;
    end
  end

  uart_baud_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .baud (baud_q),
    .tick (tick)
  );

  // State register plus registered line and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      bit_idx  <= bit_idx_next;
      stop_idx <= stop_idx_next;
      tx       <= tx_next;
      busy     <= (state_next != ST_IDLE);
    end
  end

  // Next-state; tx is derived from the state being entered so it lines up
  // with the registered state (one-cycle accept-to-start latency).
  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    tx_next       = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_START;
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + BIT_IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (two_stop && !stop_idx) begin
            stop_idx_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    unique case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = data_q[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_bit;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, meaning clk frequency in Hz (32-bit).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_data  input  8  byte to transmit.
REQ-005 SHALL have port valid  input  1  tx_data and config offered.
REQ-006 SHALL have port ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port baudrate  input  32  line rate in bit/s.
REQ-008 SHALL have port stop_bits  input  2  0 = 1 stop bit; 1..3 = 2 stop bits.
REQ-009 SHALL have port parity_en  input  1  append parity bit.
REQ-010 SHALL have port parity_type  input  1  0 = even, 1 = odd.
REQ-011 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-012 SHALL have port busy  output  1  frame in progress (state != IDLE).

Function
REQ-013 SHALL transfer a byte on a rising edge where valid && ready; ready = (state == IDLE) && (baudrate != 0), combinational.
REQ-014 SHALL latch tx_data, baudrate, stop_bits, parity_en, parity_type at accept; later input changes do not affect the frame in flight.
REQ-015 SHALL use FSM IDLE -> START -> DATA -> PARITY (only if latched parity_en) -> STOP -> IDLE.
REQ-016 SHALL drive tx = 0 in START, data bits LSB-first in DATA (3-bit index 0..7), parity bit in PARITY, 1 in STOP and IDLE.
REQ-017 SHALL compute parity as XOR of the 8 data bits, inverted when parity_type = 1.
REQ-018 SHALL time bits with a 33-bit phase accumulator: each cycle acc += baud; when acc >= CLK_FREQ, emit a one-cycle tick and acc -= CLK_FREQ.
REQ-019 SHALL clear the accumulator at accept; each bit state lasts until the next tick, then advances.
REQ-020 SHALL, when baud >= CLK_FREQ, tick every cycle and hold acc at 0.
REQ-021 SHALL have tx go low on the cycle after accept (one-cycle latency).
REQ-022 SHALL leave STOP after 1 or 2 ticks per latched stop_bits; ready rises in the same cycle IDLE is entered.
REQ-023 SHALL support back-to-back frames: valid held high yields a new START one cycle after STOP ends, with no extra idle bit.
REQ-024 SHALL never accept when baudrate == 0 (ready stays low).

Reset
REQ-025 SHALL, on rst low, asynchronously force state IDLE, tx = 1, busy = 0, acc = 0, bit index = 0, latched registers = 0; ready follows REQ-013.
REQ-026 SHALL abort any frame in flight on reset; tx returns high immediately, without completing the stop bit.

Configuration
REQ-027 SHALL honour parity_en and parity_type per REQ-015 and REQ-017 when UART_TX_PARITY_EN is defined.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and parity logic, ignore parity_en and parity_type, and always send 8N1/8N2.

Structure
REQ-029 SHALL take from package uart_pkg: the FSM state enum, the stop-bit encoding constants and the parity-type constants (shared with uart_rx).
REQ-030 SHALL place the accumulator and tick logic in sub-module uart_baud_gen (inputs clk, rst, clear, baud; output tick).

Verification
REQ-031 SHALL check: CLK_FREQ = 25e6, baudrate = 6250000 (tick every 4 cycles), tx_data = 0x36, 8N1 -> tx = 0,0,1,1,0,1,1,0,0,1, each bit 4 cycles, ready low for 40 cycles.
REQ-032 SHALL check: same byte, parity_en = 1 -> even parity bit 0; with parity_type = 1 -> odd parity bit 1; frame is 11 bits.
REQ-033 SHALL check: baudrate = 115200 -> start-to-stop-end duration 2170 +/- 1 cycles for 8N1; stop_bits = 2 adds 217 +/- 1 cycles.
REQ-034 SHALL check: valid held, bytes 0x32 then 0x38 -> second start bit begins exactly 1 cycle after the first stop bit ends.
REQ-035 SHALL check: rst pulsed low during data bit 3 -> tx = 1 and busy = 0 at once; next frame after release is correct and complete.
REQ-036 SHALL check: baudrate = 0 with valid = 1 -> ready = 0, tx stays 1; changing tx_data mid-frame does not alter the emitted bits.
